// File: rtl/tlb_fill_unit_if.sv
// Lookup, flush and page-walker signals of tlb_fill_unit.
// slave  : the TLB fill unit itself.
// master : the surrounding pipeline and page walker.
// Optional TLB_PERF_CTR_EN adds the hit/miss counter outputs.
interface tlb_fill_unit_if;
    // Lookup side
    logic        IN_lkValid;
    logic [19:0] IN_lkVpn;
    logic        IN_lkStore;
    logic        IN_lkExec;
    logic        IN_userMode;
    logic        IN_sum;
    logic [21:0] IN_rootPPN;
    logic        IN_flush;

    logic        OUT_resValid;
    logic        OUT_resHit;
    logic        OUT_resFault;
    logic [19:0] OUT_resPpn;
    logic        OUT_busy;

    // Page-walker side
    logic        OUT_pwRqValid;
    logic [31:0] OUT_pwRqAddr;
    logic [21:0] OUT_pwRqRoot;
    logic        IN_pwBusy;
    logic        IN_pwValid;
    logic [1:0]  IN_pwRqID;
    logic        IN_pwSuper;
    logic        IN_pwFault;
    logic        IN_pwGlobl;
    logic        IN_pwUser;
    logic [21:0] IN_pwPpn;
    logic [19:0] IN_pwVpn;
    logic [2:0]  IN_pwRwx;

`ifdef TLB_PERF_CTR_EN
    logic [31:0] OUT_hitCnt;
    logic [31:0] OUT_missCnt;
`endif

    modport slave (
        input  IN_lkValid, IN_lkVpn, IN_lkStore, IN_lkExec, IN_userMode, IN_sum,
               IN_rootPPN, IN_flush,
        input  IN_pwBusy, IN_pwValid, IN_pwRqID, IN_pwSuper, IN_pwFault, IN_pwGlobl,
               IN_pwUser, IN_pwPpn, IN_pwVpn, IN_pwRwx,
        output OUT_resValid, OUT_resHit, OUT_resFault, OUT_resPpn, OUT_busy,
        output OUT_pwRqValid, OUT_pwRqAddr, OUT_pwRqRoot
`ifdef TLB_PERF_CTR_EN
        , output OUT_hitCnt, OUT_missCnt
`endif
    );

    modport master (
        output IN_lkValid, IN_lkVpn, IN_lkStore, IN_lkExec, IN_userMode, IN_sum,
               IN_rootPPN, IN_flush,
        output IN_pwBusy, IN_pwValid, IN_pwRqID, IN_pwSuper, IN_pwFault, IN_pwGlobl,
               IN_pwUser, IN_pwPpn, IN_pwVpn, IN_pwRwx,
        input  OUT_resValid, OUT_resHit, OUT_resFault, OUT_resPpn, OUT_busy,
        input  OUT_pwRqValid, OUT_pwRqAddr, OUT_pwRqRoot
`ifdef TLB_PERF_CTR_EN
        , input OUT_hitCnt, OUT_missCnt
`endif
    );
endinterface

// File: rtl/tlb_fill_unit.sv
// Fully-associative TLB in front of the page walker.
// One lookup per cycle with a registered (1-cycle) result; a miss while idle launches a
// single page walk whose result fills the entry at a round-robin replacement pointer.
// Permissions are evaluated per lookup, so entries survive privilege changes.
// A faulting walk is remembered in a one-entry fault latch and reported on the next
// lookup of that vpn.
// Optional feature: define TLB_PERF_CTR_EN to add OUT_hitCnt / OUT_missCnt.
module tlb_fill_unit #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter logic [1:0]  RQ_ID       = 2'd0
) (
    input logic             clk,
    input logic             rst,
    tlb_fill_unit_if.slave  bus
);

    localparam int unsigned IdxW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

    // Entry storage
    logic [NUM_ENTRIES-1:0] entValidQ;
    logic [NUM_ENTRIES-1:0] entUserQ;
    logic [NUM_ENTRIES-1:0] entGloblQ;
    logic [NUM_ENTRIES-1:0] entSuperQ;
    logic [19:0]            entVpnQ [NUM_ENTRIES];
    logic [19:0]            entPpnQ [NUM_ENTRIES];
    logic [2:0]             entRwxQ [NUM_ENTRIES];
    logic [IdxW-1:0]        ptrQ;

    // Walk control
    state_t      stateQ, stateD;
    logic [19:0] walkVpnQ;
    logic [21:0] walkRootQ;
    logic        discardQ;
    logic        startWalk;
    logic        walkDone;
    logic        pwMine;
    logic        pwAccept;
    logic        doFill;
    logic        doLatch;

    // Fault latch
    logic        faultValidQ;
    logic [19:0] faultVpnQ;

    // Lookup datapath
    logic            lkMatch;
    logic [IdxW-1:0] lkIdx;
    logic [2:0]      selRwx;
    logic            selUser;
    logic            selSuper;
    logic [19:0]     selPpn;
    logic            latchHit;
    logic            permFault;
    logic            lkHit;
    logic            lkFault;
    logic [19:0]     lkPpn;

    // Result registers
    logic        resValidQ;
    logic        resHitQ;
    logic        resFaultQ;
    logic [19:0] resPpnQ;

    // Associative match; iterate downwards so the lowest matching index wins.
    always_comb begin
        lkMatch = 1'b0;
        lkIdx   = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (entValidQ[i] &&
                (entSuperQ[i] ? (entVpnQ[i][19:10] == bus.IN_lkVpn[19:10])
                              : (entVpnQ[i] == bus.IN_lkVpn))) begin
                lkMatch = 1'b1;
                lkIdx   = i[IdxW-1:0];
            end
        end
    end

    // Permission check and hit/fault/ppn selection for the current lookup.
    always_comb begin
        selRwx   = entRwxQ[lkIdx];
        selUser  = entUserQ[lkIdx];
        selSuper = entSuperQ[lkIdx];
        selPpn   = selSuper ? {entPpnQ[lkIdx][19:10], bus.IN_lkVpn[9:0]} : entPpnQ[lkIdx];

        // rwx is {r, w, x}
        permFault = (bus.IN_lkStore && !selRwx[1])
                 || (bus.IN_lkExec && !selRwx[0])
                 || (!bus.IN_lkStore && !bus.IN_lkExec && !selRwx[2])
                 || (bus.IN_userMode && !selUser)
                 || (!bus.IN_userMode && selUser && (bus.IN_lkExec || !bus.IN_sum));

        latchHit = faultValidQ && (faultVpnQ == bus.IN_lkVpn);

        // A lookup sampled in a flush cycle always misses.
        lkHit   = !bus.IN_flush && (latchHit || lkMatch);
        lkFault = lkHit && (latchHit || permFault);
        lkPpn   = (lkHit && !latchHit) ? selPpn : 20'd0;
    end

    // Walk FSM next state: IDLE -> REQ on a miss, REQ -> WAIT on accept, back on result.
    always_comb begin
        stateD    = stateQ;
        startWalk = 1'b0;
        walkDone  = 1'b0;
        pwMine    = bus.IN_pwValid && (bus.IN_pwRqID == RQ_ID);
        pwAccept  = bus.IN_pwBusy && (bus.IN_pwRqID == RQ_ID);
        case (stateQ)
            StIdle: begin
                if (bus.IN_lkValid && !lkHit && !bus.IN_flush) begin
                    stateD    = StReq;
                    startWalk = 1'b1;
                end
            end
            StReq: begin
                // A result may overtake the accept; treat it exactly as in WAIT.
                if (pwMine) begin
                    stateD   = StIdle;
                    walkDone = 1'b1;
                end else if (pwAccept) begin
                    stateD = StWait;
                end
            end
            StWait: begin
                if (pwMine) begin
                    stateD   = StIdle;
                    walkDone = 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase

        // A flush in the completion cycle discards the result just like an earlier one.
        doFill  = walkDone && !discardQ && !bus.IN_flush && !bus.IN_pwFault;
        doLatch = walkDone && !discardQ && !bus.IN_flush && bus.IN_pwFault;
    end

    // FSM state register, walk request latches and discard flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= StIdle;
            walkVpnQ  <= '0;
            walkRootQ <= '0;
            discardQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (startWalk) begin
                walkVpnQ  <= bus.IN_lkVpn;
                walkRootQ <= bus.IN_rootPPN;
            end
            if (walkDone) begin
                discardQ <= 1'b0;
            end else if (bus.IN_flush && (stateQ != StIdle)) begin
                discardQ <= 1'b1;
            end
        end
    end

    // Entry valid bits and replacement pointer (power-of-two depth wraps naturally).
    always_ff @(posedge clk) begin
        if (rst) begin
            entValidQ <= '0;
            ptrQ      <= '0;
        end else begin
            if (bus.IN_flush) begin
                entValidQ <= '0;
            end else if (doFill) begin
                entValidQ[ptrQ] <= 1'b1;
            end
            if (doFill) begin
                ptrQ <= ptrQ + 1'b1;
            end
        end
    end

    // Entry payload; qualified by the valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        if (doFill) begin
            entVpnQ[ptrQ]   <= bus.IN_pwVpn;
            entPpnQ[ptrQ]   <= bus.IN_pwPpn[19:0];
            entRwxQ[ptrQ]   <= bus.IN_pwRwx;
            entUserQ[ptrQ]  <= bus.IN_pwUser;
            entGloblQ[ptrQ] <= bus.IN_pwGlobl;
            entSuperQ[ptrQ] <= bus.IN_pwSuper;
        end
    end

    // Fault latch: set by a faulting walk, consumed by the next lookup of that vpn.
    always_ff @(posedge clk) begin
        if (rst || bus.IN_flush) begin
            faultValidQ <= 1'b0;
            faultVpnQ   <= '0;
        end else if (doLatch) begin
            faultValidQ <= 1'b1;
            faultVpnQ   <= bus.IN_pwVpn;
        end else if (bus.IN_lkValid && latchHit) begin
            faultValidQ <= 1'b0;
        end
    end

    // Registered lookup result.
    always_ff @(posedge clk) begin
        if (rst) begin
            resValidQ <= 1'b0;
            resHitQ   <= 1'b0;
            resFaultQ <= 1'b0;
            resPpnQ   <= '0;
        end else begin
            resValidQ <= bus.IN_lkValid;
            resHitQ   <= bus.IN_lkValid && lkHit;
            resFaultQ <= bus.IN_lkValid && lkFault;
            resPpnQ   <= lkPpn;
        end
    end

    assign bus.OUT_resValid  = resValidQ;
    assign bus.OUT_resHit    = resHitQ;
    assign bus.OUT_resFault  = resFaultQ;
    assign bus.OUT_resPpn    = resPpnQ;
    assign bus.OUT_busy      = (stateQ != StIdle);
    assign bus.OUT_pwRqValid = (stateQ == StReq);
    assign bus.OUT_pwRqAddr  = {walkVpnQ, 12'h000};
    assign bus.OUT_pwRqRoot  = walkRootQ;

`ifdef TLB_PERF_CTR_EN
    logic [31:0] hitCntQ;
    logic [31:0] missCntQ;

    // Lookup statistics; deliberately survive flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hitCntQ  <= '0;
            missCntQ <= '0;
        end else if (bus.IN_lkValid) begin
            if (lkHit) begin
                hitCntQ <= hitCntQ + 32'd1;
            end else begin
                missCntQ <= missCntQ + 32'd1;
            end
        end
    end

    assign bus.OUT_hitCnt  = hitCntQ;
    assign bus.OUT_missCnt = missCntQ;
`else
    // No performance counters in this build.
`endif

    // Global bit is kept for the entry format but flush invalidates everything anyway;
    // the upper walker PPN bits fall outside the 20-bit physical page number.
    logic unusedBits;
    assign unusedBits = ^{entGloblQ, bus.IN_pwPpn[21:20]};

endmodule

// File: tb/tb_tlb_fill_unit.sv
// Directed self-checking bench for tlb_fill_unit (NUM_ENTRIES=8, RQ_ID=0).
module tb_tlb_fill_unit;

    localparam logic [1:0] RqId = 2'd0;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nErrors = 0;

    always #5 clk = ~clk;

    tlb_fill_unit_if bus ();

    tlb_fill_unit #(
        .NUM_ENTRIES (8),
        .RQ_ID       (RqId)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle lookup; on return the registered result is visible.
    task automatic lookup(input logic [19:0] vpn, input logic st, input logic ex,
                          input logic um, input logic sm);
        bus.IN_lkValid  = 1'b1;
        bus.IN_lkVpn    = vpn;
        bus.IN_lkStore  = st;
        bus.IN_lkExec   = ex;
        bus.IN_userMode = um;
        bus.IN_sum      = sm;
        step();
        bus.IN_lkValid  = 1'b0;
        bus.IN_lkStore  = 1'b0;
        bus.IN_lkExec   = 1'b0;
    endtask

    task automatic expectRes(input string tag, input logic hit, input logic fault,
                             input logic [19:0] ppn);
        check({tag, ".valid"}, 32'(bus.OUT_resValid), 32'd1);
        check({tag, ".hit"}, 32'(bus.OUT_resHit), 32'(hit));
        if (hit) begin
            check({tag, ".fault"}, 32'(bus.OUT_resFault), 32'(fault));
            check({tag, ".ppn"}, 32'(bus.OUT_resPpn), 32'(ppn));
        end
    endtask

    // Accept the pending request, then return a result. With peek set, a lookup of the
    // same vpn is issued in the result cycle and must still miss.
    task automatic serveWalk(input logic [19:0] vpn, input logic [21:0] ppn,
                             input logic [2:0] rwx, input logic usr, input logic sup,
                             input logic flt, input logic peek);
        int n = 0;
        while (!bus.OUT_pwRqValid && n < 20) begin
            step();
            n++;
        end
        if (!bus.OUT_pwRqValid) begin
            check("walkTimeout", 32'(bus.OUT_pwRqValid), 32'd1);
            return;
        end
        check("rqAddr", bus.OUT_pwRqAddr, {vpn, 12'h000});
        bus.IN_pwBusy = 1'b1;
        bus.IN_pwRqID = RqId;
        step();
        bus.IN_pwBusy = 1'b0;
        check("rqDrop", 32'(bus.OUT_pwRqValid), 32'd0);
        check("busyWait", 32'(bus.OUT_busy), 32'd1);
        bus.IN_pwValid = 1'b1;
        bus.IN_pwVpn   = vpn;
        bus.IN_pwPpn   = ppn;
        bus.IN_pwRwx   = rwx;
        bus.IN_pwUser  = usr;
        bus.IN_pwSuper = sup;
        bus.IN_pwFault = flt;
        bus.IN_pwGlobl = 1'b0;
        if (peek) begin
            bus.IN_lkValid = 1'b1;
            bus.IN_lkVpn   = vpn;
        end
        step();
        bus.IN_pwValid = 1'b0;
        bus.IN_lkValid = 1'b0;
        check("walkIdle", 32'(bus.OUT_busy), 32'd0);
        if (peek) begin
            check("peekMiss", 32'(bus.OUT_resHit), 32'd0);
        end
    endtask

    initial begin
`ifdef TLB_PERF_CTR_EN
        logic [31:0] hc0;
        logic [31:0] mc0;
`endif
        rst             = 1'b1;
        bus.IN_lkValid  = 1'b0;
        bus.IN_lkVpn    = '0;
        bus.IN_lkStore  = 1'b0;
        bus.IN_lkExec   = 1'b0;
        bus.IN_userMode = 1'b0;
        bus.IN_sum      = 1'b0;
        bus.IN_rootPPN  = 22'h1ABCDE;
        bus.IN_flush    = 1'b0;
        bus.IN_pwBusy   = 1'b0;
        bus.IN_pwValid  = 1'b0;
        bus.IN_pwRqID   = 2'd0;
        bus.IN_pwSuper  = 1'b0;
        bus.IN_pwFault  = 1'b0;
        bus.IN_pwGlobl  = 1'b0;
        bus.IN_pwUser   = 1'b0;
        bus.IN_pwPpn    = '0;
        bus.IN_pwVpn    = '0;
        bus.IN_pwRwx    = '0;
        step();
        step();
        check("rst.resValid", 32'(bus.OUT_resValid), 32'd0);
        check("rst.hit", 32'(bus.OUT_resHit), 32'd0);
        check("rst.busy", 32'(bus.OUT_busy), 32'd0);
        check("rst.rqValid", 32'(bus.OUT_pwRqValid), 32'd0);
`ifdef TLB_PERF_CTR_EN
        check("rst.hitCnt", bus.OUT_hitCnt, 32'd0);
        check("rst.missCnt", bus.OUT_missCnt, 32'd0);
`endif
        rst = 1'b0;
        step();

        // Cold miss, walk, re-lookup (entry 0)
        lookup(20'h12345, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("cold", 1'b0, 1'b0, 20'h0);
        check("cold.rqValid", 32'(bus.OUT_pwRqValid), 32'd1);
        check("cold.root", 32'(bus.OUT_pwRqRoot), 32'h1ABCDE);
        check("cold.busy", 32'(bus.OUT_busy), 32'd1);
        serveWalk(20'h12345, 22'h000ABC, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        lookup(20'h12345, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("coldHit", 1'b1, 1'b0, 20'h00ABC);

        // Superpage (entry 1); a result for another requester is ignored
        lookup(20'h0A800, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("supMiss", 1'b0, 1'b0, 20'h0);
        bus.IN_pwValid = 1'b1;
        bus.IN_pwBusy  = 1'b1;
        bus.IN_pwRqID  = 2'd2;
        bus.IN_pwVpn   = 20'h0A800;
        bus.IN_pwFault = 1'b0;
        step();
        bus.IN_pwValid = 1'b0;
        bus.IN_pwBusy  = 1'b0;
        check("otherId.rqValid", 32'(bus.OUT_pwRqValid), 32'd1);
        serveWalk(20'h0A800, 22'h02C000, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
        lookup(20'h0A9FF, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("supHit", 1'b1, 1'b0, 20'h2C1FF);
        lookup(20'h0AC00, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("supOut", 1'b0, 1'b0, 20'h0);

        // Permissions on a read-only user page (entry 2)
        serveWalk(20'h0AC00, 22'h000777, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
        lookup(20'h0AC00, 1'b1, 1'b0, 1'b1, 1'b0);
        expectRes("permStore", 1'b1, 1'b1, 20'h00777);
        lookup(20'h0AC00, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("permSupNoSum", 1'b1, 1'b1, 20'h00777);
        lookup(20'h0AC00, 1'b0, 1'b0, 1'b0, 1'b1);
        expectRes("permSupSum", 1'b1, 1'b0, 20'h00777);
        lookup(20'h0AC00, 1'b0, 1'b1, 1'b1, 1'b0);
        expectRes("permUserExec", 1'b1, 1'b1, 20'h00777);
        lookup(20'h0AC00, 1'b0, 1'b0, 1'b1, 1'b0);
        expectRes("permUserLoad", 1'b1, 1'b0, 20'h00777);

        // Fault latch
        lookup(20'h00100, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("fltMiss", 1'b0, 1'b0, 20'h0);
        serveWalk(20'h00100, 22'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        lookup(20'h12345, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("fltOther", 1'b1, 1'b0, 20'h00ABC);
        lookup(20'h00100, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("fltHit", 1'b1, 1'b1, 20'h0);
        check("fltHit.noWalk", 32'(bus.OUT_busy), 32'd0);
        lookup(20'h00100, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("fltCleared", 1'b0, 1'b0, 20'h0);
        check("fltCleared.rq", 32'(bus.OUT_pwRqValid), 32'd1);
        serveWalk(20'h00100, 22'h000F00, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush in WAIT discards the walk result
        lookup(20'h00200, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("flMiss", 1'b0, 1'b0, 20'h0);
        bus.IN_pwBusy = 1'b1;
        bus.IN_pwRqID = RqId;
        step();
        bus.IN_pwBusy  = 1'b0;
        bus.IN_flush   = 1'b1;
        bus.IN_lkValid = 1'b1;
        bus.IN_lkVpn   = 20'h12345;
        step();
        bus.IN_flush   = 1'b0;
        bus.IN_lkValid = 1'b0;
        expectRes("flCycle", 1'b0, 1'b0, 20'h0);
        check("flBusy", 32'(bus.OUT_busy), 32'd1);
        bus.IN_pwValid = 1'b1;
        bus.IN_pwRqID  = RqId;
        bus.IN_pwVpn   = 20'h00200;
        bus.IN_pwPpn   = 22'h000321;
        bus.IN_pwRwx   = 3'b111;
        bus.IN_pwFault = 1'b0;
        step();
        bus.IN_pwValid = 1'b0;
        check("flDone", 32'(bus.OUT_busy), 32'd0);
        lookup(20'h00200, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("flNoFill", 1'b0, 1'b0, 20'h0);
        check("flNewRq", 32'(bus.OUT_pwRqValid), 32'd1);
        serveWalk(20'h00200, 22'h000321, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        lookup(20'h00200, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("postFill", 1'b1, 1'b0, 20'h00321);
        lookup(20'h12345, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("flushedOld", 1'b0, 1'b0, 20'h0);
        serveWalk(20'h12345, 22'h000ABC, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);

        // Replacement wrap: clear, then 9 fills into 8 entries
        bus.IN_flush = 1'b1;
        step();
        bus.IN_flush = 1'b0;
        for (int k = 0; k < 9; k++) begin
            lookup(20'h30000 + 20'(k), 1'b0, 1'b0, 1'b0, 1'b0);
            check("wrapFillMiss", 32'(bus.OUT_resHit), 32'd0);
            serveWalk(20'h30000 + 20'(k), 22'h040 + 22'(k), 3'b110, 1'b0, 1'b0, 1'b0,
                      1'b0);
        end
`ifdef TLB_PERF_CTR_EN
        hc0 = bus.OUT_hitCnt;
        mc0 = bus.OUT_missCnt;
`endif
        for (int k = 1; k < 9; k++) begin
            lookup(20'h30000 + 20'(k), 1'b0, 1'b0, 1'b0, 1'b0);
            expectRes("wrapHit", 1'b1, 1'b0, 20'h00040 + 20'(k));
        end
        lookup(20'h30000, 1'b0, 1'b0, 1'b0, 1'b0);
        expectRes("wrapEvicted", 1'b0, 1'b0, 20'h0);
`ifdef TLB_PERF_CTR_EN
        check("hitCntDelta", bus.OUT_hitCnt - hc0, 32'd8);
        check("missCntDelta", bus.OUT_missCnt - mc0, 32'd1);
`endif

        // Reset while a request is pending
        check("preRst.rq", 32'(bus.OUT_pwRqValid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midRst.busy", 32'(bus.OUT_busy), 32'd0);
        bus.IN_pwValid = 1'b1;
        bus.IN_pwRqID  = RqId;
        bus.IN_pwVpn   = 20'h30000;
        step();
        bus.IN_pwValid = 1'b0;
        check("midRst.ignored", 32'(bus.OUT_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
